// File: rtl/csr_access_sequencer.sv
// rtl/csr_access_sequencer.sv - CSR instruction, trap-entry and mret sequencer in front of a CSR file.
// Optional read-only CSR protection is enabled by defining CSR_ACCESS_RO_CHECK_EN.
module csr_access_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_src,
  input  logic        req_nowr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_illegal,
  input  logic        trap_valid,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic        mret_valid,
  output logic [11:0] csr_read_target,
  input  logic [63:0] csr_read_data,
  output logic        csr_wdEn,
  output logic [11:0] csr_write_target,
  output logic [63:0] csr_write_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  typedef enum logic [3:0] {
    IDLE, INSN, RESP, T_EPC, T_CAUSE, T_STATUS, T_VEC, M_STATUS, M_EPC, REDIR
  } state_t;

  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RC = 2'b11;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  state_t      state, next_state;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [63:0] src_q;
  logic        nowr_q;
  logic        ro_hit;
  logic [63:0] new_val;
  logic [63:0] status_trap, status_mret;

`ifdef CSR_ACCESS_RO_CHECK_EN
  assign ro_hit = (addr_q[11:10] == 2'b11) && ((op_q == OP_RW) || !nowr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 resp_illegal <= 1'b0;
    else if (state == INSN)  resp_illegal <= ro_hit;
  end
`else
  assign ro_hit       = 1'b0;
  assign resp_illegal = 1'b0;
`endif

  // Trap entry stacks MIE into MPIE and enters M-mode; mret unstacks it.
  always_comb begin
    status_trap        = csr_read_data;
    status_trap[7]     = csr_read_data[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_mret        = csr_read_data;
    status_mret[3]     = csr_read_data[7];
    status_mret[7]     = 1'b1;
    status_mret[12:11] = 2'b00;
  end

  always_comb begin
    case (op_q)
      OP_RW:   new_val = src_q;
      OP_RC:   new_val = csr_read_data & ~src_q;
      default: new_val = csr_read_data | src_q;
    endcase
  end

  assign req_ready      = !rst && (state == IDLE) && !trap_valid && !mret_valid;
  assign resp_valid     = (state == RESP);
  assign redirect_valid = (state == REDIR);

  always_comb begin
    next_state       = state;
    csr_read_target  = 12'h000;
    csr_wdEn         = 1'b0;
    csr_write_target = 12'h000;
    csr_write_data   = 64'h0;
    case (state)
      IDLE: begin
        if (trap_valid)      next_state = T_EPC;
        else if (mret_valid) next_state = M_STATUS;
        else if (req_valid)  next_state = INSN;
      end
      INSN: begin
        csr_read_target  = addr_q;
        csr_wdEn         = !nowr_q && !ro_hit;
        csr_write_target = addr_q;
        csr_write_data   = new_val;
        next_state       = RESP;
      end
      RESP: if (resp_ready) next_state = IDLE;
      T_EPC: begin
        csr_wdEn         = 1'b1;
        csr_write_target = A_MEPC;
        csr_write_data   = trap_pc & ~64'h3;
        next_state       = T_CAUSE;
      end
      T_CAUSE: begin
        csr_wdEn         = 1'b1;
        csr_write_target = A_MCAUSE;
        csr_write_data   = trap_cause;
        next_state       = T_STATUS;
      end
      T_STATUS: begin
        csr_read_target  = A_MSTATUS;
        csr_wdEn         = 1'b1;
        csr_write_target = A_MSTATUS;
        csr_write_data   = status_trap;
        next_state       = T_VEC;
      end
      T_VEC: begin
        csr_read_target = A_MTVEC;
        next_state      = REDIR;
      end
      M_STATUS: begin
        csr_read_target  = A_MSTATUS;
        csr_wdEn         = 1'b1;
        csr_write_target = A_MSTATUS;
        csr_write_data   = status_mret;
        next_state       = M_EPC;
      end
      M_EPC: begin
        csr_read_target = A_MEPC;
        next_state      = REDIR;
      end
      REDIR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= 12'h000;
      src_q       <= 64'h0;
      nowr_q      <= 1'b0;
      resp_data   <= 64'h0;
      redirect_pc <= 64'h0;
    end else begin
      state <= next_state;
      if (req_valid && req_ready) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        // Reserved op behaves as a set with a zero mask.
        src_q  <= (req_op == 2'b00) ? 64'h0 : req_src;
        nowr_q <= req_nowr;
      end
      if (state == INSN)  resp_data   <= ro_hit ? 64'h0 : csr_read_data;
      if (state == T_VEC) redirect_pc <= csr_read_data & ~64'h3;
      if (state == M_EPC) redirect_pc <= csr_read_data;
    end
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// tb/tb_csr_access_sequencer.sv - self-checking bench for csr_access_sequencer with a CSR file and reference model.
module tb_csr_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_nowr;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [63:0] req_src;
  logic        resp_valid, resp_ready, resp_illegal;
  logic [63:0] resp_data;
  logic        trap_valid, mret_valid;
  logic [63:0] trap_pc, trap_cause;
  logic [11:0] csr_read_target, csr_write_target;
  logic [63:0] csr_read_data, csr_write_data;
  logic        csr_wdEn;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  csr_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_nowr(req_nowr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_illegal(resp_illegal),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_valid(mret_valid),
    .csr_read_target(csr_read_target), .csr_read_data(csr_read_data),
    .csr_wdEn(csr_wdEn), .csr_write_target(csr_write_target),
    .csr_write_data(csr_write_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // CSR file: write sampled on negedge, visible to reads from the next cycle.
  logic [63:0] mem [0:4095];
  logic        pend;
  logic [11:0] pend_a;
  logic [63:0] pend_d;
  assign csr_read_data = mem[csr_read_target];
  always @(negedge clk) begin
    pend   <= csr_wdEn;
    pend_a <= csr_write_target;
    pend_d <= csr_write_data;
  end
  always @(posedge clk) if (pend) mem[pend_a] <= pend_d;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model state and expectation queues.
  logic [63:0] mdl [0:4095];
  logic [11:0] exp_wa[$];
  logic [63:0] exp_wd[$];
  logic [63:0] exp_rd[$];
  logic        exp_ri[$];
  logic [63:0] exp_rp[$];
  logic [63:0] last_resp, last_redir;
  logic        prev_resp = 1'b0, prev_redir = 1'b0;

  task automatic exp_write(input logic [11:0] a, input logic [63:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    mdl[a] = d;
  endtask

  task automatic model_insn(input logic [1:0] op, input logic [11:0] a, input logic [63:0] s, input logic nw);
    logic [63:0] old, nv, m;
    logic ill;
    old = mdl[a];
    m = (op == 2'b00) ? 64'h0 : s;
    if (op == 2'b01)      nv = m;
    else if (op == 2'b11) nv = old & ~m;
    else                  nv = old | m;
    ill = 1'b0;
`ifdef CSR_ACCESS_RO_CHECK_EN
    ill = (a >= 12'hC00) && (op == 2'b01 || !nw);
`endif
    if (!nw && !ill) exp_write(a, nv);
    exp_rd.push_back(ill ? 64'h0 : old);
    exp_ri.push_back(ill);
  endtask

  task automatic model_trap(input logic [63:0] pc, input logic [63:0] cause);
    logic [63:0] st, nv;
    exp_write(12'h341, pc - (pc % 4));
    exp_write(12'h342, cause);
    st = mdl[12'h300];
    nv = (st & ~64'h1888) | 64'h1800 | (((st >> 3) & 64'h1) << 7);
    exp_write(12'h300, nv);
    exp_rp.push_back(mdl[12'h305] - (mdl[12'h305] % 4));
  endtask

  task automatic model_mret;
    logic [63:0] st, nv;
    st = mdl[12'h300];
    nv = (st & ~64'h1888) | 64'h80 | (((st >> 7) & 64'h1) << 3);
    exp_write(12'h300, nv);
    exp_rp.push_back(mdl[12'h341]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (csr_wdEn) begin
        if (exp_wa.size() == 0) chk("unexpected_write", {52'h0, csr_write_target}, 64'hFFFF);
        else begin
          chk("wr_addr", {52'h0, csr_write_target}, {52'h0, exp_wa.pop_front()});
          chk("wr_data", csr_write_data, exp_wd.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_rd.size() == 0) chk("unexpected_resp", resp_data, 64'hFFFF_FFFF);
        else begin
          chk("resp_data", resp_data, exp_rd[0]);
          chk("resp_illegal", {63'h0, resp_illegal}, {63'h0, exp_ri[0]});
          if (!prev_resp) chk("resp_latency", cyc - acc_cyc, 2);
          last_resp = resp_data;
          if (resp_ready) begin
            void'(exp_rd.pop_front());
            void'(exp_ri.pop_front());
          end
        end
      end
      if (redirect_valid) begin
        chk("redirect_pulse", {63'h0, prev_redir}, 64'h0);
        if (exp_rp.size() == 0) chk("unexpected_redirect", redirect_pc, 64'hFFFF_FFFF);
        else chk("redirect_pc", redirect_pc, exp_rp.pop_front());
        last_redir = redirect_pc;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
    end
    prev_resp  = resp_valid;
    prev_redir = redirect_valid;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {35'h0, req_ready, resp_valid, resp_illegal, csr_wdEn, redirect_valid,
                          csr_read_target, csr_write_target}, 64'h0);
    chk({tag, "_resp_data"}, resp_data, 64'h0);
    chk({tag, "_wdata"}, csr_write_data, 64'h0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'h0);
  endtask

  task automatic handshake;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("req_handshake", {63'h0, ok}, 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int hold);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    chk("resp_arrival", {63'h0, ok}, 64'h1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic wait_redir;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (redirect_valid) begin ok = 1'b1; break; end
    end
    chk("redirect_arrival", {63'h0, ok}, 64'h1);
    @(posedge clk); #1;
  endtask

  task automatic insn(input logic [1:0] op, input logic [11:0] a, input logic [63:0] s,
                      input logic nw, input int hold);
    model_insn(op, a, s, nw);
    req_op = op; req_addr = a; req_src = s; req_nowr = nw; req_valid = 1'b1;
    handshake();
    wait_resp(hold);
  endtask

  task automatic do_trap(input logic [63:0] pc, input logic [63:0] cause);
    model_trap(pc, cause);
    trap_pc = pc; trap_cause = cause; trap_valid = 1'b1;
    wait_redir();
    trap_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mdl[i] = 64'h0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h0; req_src = 64'h0;
    req_nowr = 1'b0; resp_ready = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    trap_pc = 64'h0; trap_cause = 64'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    insn(2'b01, 12'h340, 64'h1234, 1'b0, 0);
    insn(2'b01, 12'h340, 64'hDEAD, 1'b0, 1);
    chk("rw_old_lit", last_resp, 64'h1234);
    chk("rw_mem_lit", mem[12'h340], 64'hDEAD);

    insn(2'b01, 12'h300, 64'h88, 1'b0, 0);
    insn(2'b11, 12'h300, 64'h8, 1'b0, 0);
    chk("rc_old_lit", last_resp, 64'h88);
    chk("rc_mem_lit", mem[12'h300], 64'h80);

    insn(2'b10, 12'h300, 64'hFF, 1'b1, 2);
    chk("rs_nowr_resp_lit", last_resp, 64'h80);
    chk("rs_nowr_mem_lit", mem[12'h300], 64'h80);

    insn(2'b10, 12'h340, 64'hF0000, 1'b0, 3);
    chk("rs_mem_lit", mem[12'h340], 64'hFDEAD);
    insn(2'b00, 12'h340, 64'h55, 1'b0, 0);
    chk("rsv_mem_lit", mem[12'h340], 64'hFDEAD);

    insn(2'b01, 12'h305, 64'h8000_0101, 1'b0, 0);
    insn(2'b01, 12'h300, 64'h8, 1'b0, 0);
    do_trap(64'h8000_0004, 64'h2);
    chk("trap_mepc_lit", mem[12'h341], 64'h8000_0004);
    chk("trap_mcause_lit", mem[12'h342], 64'h2);
    chk("trap_mstatus_lit", mem[12'h300], 64'h1880);
    chk("trap_redirect_lit", last_redir, 64'h8000_0100);

    insn(2'b01, 12'h341, 64'h8000_0010, 1'b0, 0);
    model_mret();
    mret_valid = 1'b1;
    wait_redir();
    mret_valid = 1'b0;
    chk("mret_mstatus_lit", mem[12'h300], 64'h88);
    chk("mret_redirect_lit", last_redir, 64'h8000_0010);

    // Trap and instruction offered together: trap must win.
    model_trap(64'h103, 64'hB);
    model_insn(2'b10, 12'h342, 64'h0, 1'b1);
    req_op = 2'b10; req_addr = 12'h342; req_src = 64'h0; req_nowr = 1'b1; req_valid = 1'b1;
    trap_pc = 64'h103; trap_cause = 64'hB; trap_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_vs_trap", {63'h0, req_ready}, 64'h0);
    wait_redir();
    trap_valid = 1'b0;
    handshake();
    wait_resp(0);
    chk("trap_first_mepc_lit", mem[12'h341], 64'h100);
    chk("trap_first_resp_lit", last_resp, 64'hB);

    insn(2'b01, 12'hC00, 64'h7, 1'b0, 0);
    insn(2'b10, 12'hC00, 64'h0, 1'b1, 0);
`ifdef CSR_ACCESS_RO_CHECK_EN
    chk("ro_mem_lit", mem[12'hC00], 64'h0);
`else
    chk("ro_mem_lit", mem[12'hC00], 64'h7);
`endif

    // Reset while in T_CAUSE: only the mepc write has been issued.
    exp_write(12'h341, 64'h2000);
    trap_pc = 64'h2000; trap_cause = 64'h5; trap_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    trap_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_mepc_lit", mem[12'h341], 64'h2000);
    chk("abort_mcause_lit", mem[12'h342], 64'hB);

    insn(2'b10, 12'h342, 64'h0, 1'b1, 0);
    chk("post_reset_resp_lit", last_resp, 64'hB);

    repeat (3) @(negedge clk);
    chk("pending_writes", exp_wa.size(), 0);
    chk("pending_resps", exp_rd.size(), 0);
    chk("pending_redirects", exp_rp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
